// File: rtl/fetch_stage_if.sv
// fetch_stage_if: bundles the fetch stage's control, ROM and IF/ID signals.
//   stall, branch_taken, branch_offset, jump, jump_target, jump_reg,
//   jump_reg_addr, rom_instruction : environment -> fetch stage
//   rom_address, pc, if_id_instr, if_id_pc_plus1, if_id_valid
//                                   : fetch stage -> environment
// Modports: slave = fetch stage, master = hazard unit / decode / ROM side.
interface fetch_stage_if;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        jump_reg;
  logic [31:0] jump_reg_addr;
  logic [31:0] rom_address;
  logic [31:0] rom_instruction;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus1;
  logic        if_id_valid;

  modport master (
    output stall, branch_taken, branch_offset, jump, jump_target,
           jump_reg, jump_reg_addr, rom_instruction,
    input  rom_address, pc, if_id_instr, if_id_pc_plus1, if_id_valid
  );

  modport slave (
    input  stall, branch_taken, branch_offset, jump, jump_target,
           jump_reg, jump_reg_addr, rom_instruction,
    output rom_address, pc, if_id_instr, if_id_pc_plus1, if_id_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with zero-latency word-indexed ROM and an
// IF/ID pipeline register.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : fetch_stage_if.slave (redirect/stall controls, ROM port,
//           pc and IF/ID outputs)
// Redirect priority: jump_reg > jump > branch_taken > stall > sequential.
// Redirects are honoured only in RUN with a valid IF/ID entry, since their
// targets are built from the registered IF/ID pc+step.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input logic          clk,
  input logic          reset,
  fetch_stage_if.slave bus
);

  typedef enum logic {RESET_FETCH, RUN} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc1_q, pc1_d;
  logic        valid_q, valid_d;

  logic        redirect_ok;
  logic [31:0] pc_seq;
  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;

  assign pc_seq     = pc_q + PC_STEP;
  assign branch_tgt = pc1_q + {{16{bus.branch_offset[15]}}, bus.branch_offset};
  assign jump_tgt   = {pc1_q[31:26], bus.jump_target};
  assign redirect_ok = (state_q == RUN) && valid_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RESET_FETCH;
    else       state_q <= state_d;
  end

  // Next state: leave RESET_FETCH on the first unstalled edge
  always_comb begin
    state_d = state_q;
    if (state_q == RESET_FETCH && !bus.stall) state_d = RUN;
  end

  // Output / datapath next values
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc1_d   = pc1_q;
    valid_d = valid_q;
    if (redirect_ok && (bus.jump_reg || bus.jump || bus.branch_taken)) begin
      if (bus.jump_reg)  pc_d = bus.jump_reg_addr;
      else if (bus.jump) pc_d = jump_tgt;
      else               pc_d = branch_tgt;
      // Wrong-path fetch is discarded: IF/ID becomes a bubble
      instr_d = '0;
      pc1_d   = '0;
      valid_d = 1'b0;
    end else if (!bus.stall) begin
      pc_d    = pc_seq;
      instr_d = bus.rom_instruction;
      pc1_d   = pc_seq;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc1_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc1_q   <= pc1_d;
      valid_q <= valid_d;
    end
  end

  assign bus.rom_address    = pc_q;
  assign bus.pc             = pc_q;
  assign bus.if_id_instr    = instr_q;
  assign bus.if_id_pc_plus1 = pc1_q;
  assign bus.if_id_valid    = valid_q;

endmodule
